uart_tx_framer: RTL



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_cnt.sv | 45 ++++
 rtl/uart_tx_framer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit framer, the receiver and
// the receiver's error checker.
//   UART_DATA_BITS : payload width (8)
//   PAR_ODD/EVEN   : parity_type codes; any other code means "no parity bit"
//   uart_state_e   : frame state encoding IDLE/START/DATA/PARITY/STOP
//   uart_parity_bit / uart_parity_en : parity helpers used on both sides
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic uart_parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                           input logic [1:0]                ptype);
    return (ptype == PAR_EVEN) ? ^data : ~^data;
  endfunction

  function automatic logic uart_parity_en(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises
// bit_end_o during the last cycle of each period. clear_i holds the count at 0
// so the first period after release is a full CLKS_PER_BIT cycles.
//   clk       : clock
//   rst       : synchronous active-high reset
//   clear_i   : hold counter at zero (suppresses bit_end_o)
//   bit_end_o : one-cycle pulse in the final cycle of a bit period
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_cnt: CLKS_PER_BIT must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter. Accepts a byte on send&&ready, then
// serialises start(0), 8 data bits LSB first, optional parity, stop(1).
//   clk, rst    : clock, synchronous active-high reset
//   send        : transmit request, only honoured while ready
//   data_in     : byte to transmit (latched on acceptance)
//   parity_type : 01 odd, 10 even, 00/11 none (latched on acceptance)
//   ready       : idle and able to accept a byte
//   busy        : frame in progress
//   done        : one-cycle pulse in the first idle cycle after the stop bit(s)
//   tx          : serial output, idles high
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (default one).
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  if (DATA_BITS != UART_DATA_BITS) begin : g_bad_width
    $error("uart_tx_framer: DATA_BITS must be 8");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bit_q, par_bit_d;
  logic        par_en_q, par_en_d;
  // Shared index: data bit number in DATA, stop bit number in STOP.
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        done_q, done_d;
  logic        bit_end;

  // Counter is held clear while idle so START gets a full bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          shift_d   = data_in;
          par_en_d  = uart_parity_en(parity_type);
          par_bit_d = uart_parity_bit(data_in, parity_type);
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  // Line level decoded from registered state only; the data bit is always
  // the LSB of the shift register.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = par_bit_q;
      default: tx = 1'b1;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule
